// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues BTB updates, retires one per cycle with 2-bit counter rules, and runs the invalidate walk
module btb_update_ctrl #(
  parameter int ENTRIES = 4,
  parameter int QDEPTH = 4,
  localparam int IDXW = $clog2(ENTRIES)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            flush,
  input  logic            br_valid,
  input  logic [31:0]     br_npc,
  input  logic [31:0]     br_target,
  input  logic            br_taken,
  output logic            br_ready,
  input  logic            jmp_valid,
  input  logic [31:0]     jmp_npc,
  input  logic [31:0]     jmp_target,
  output logic            jmp_ready,
  output logic [IDXW-1:0] tbl_ridx,
  input  logic            tbl_rvalid,
  input  logic [31:0]     tbl_rnpc,
  input  logic [1:0]      tbl_rctr,
  output logic            tbl_wen,
  output logic [IDXW-1:0] tbl_widx,
  output logic            tbl_wvalid,
  output logic [31:0]     tbl_wnpc,
  output logic [31:0]     tbl_wtarget,
  output logic [1:0]      tbl_wctr,
  output logic            busy
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [IDXW-1:0] walk_idx, walk_n;
  logic [PW-1:0] head, tail, tail_n;
  logic [CW-1:0] count;
  logic q_kind [QDEPTH];
  logic q_taken [QDEPTH];
  logic [31:0] q_npc [QDEPTH];
  logic [31:0] q_target [QDEPTH];
  logic clr, br_acc, jmp_acc, deq, hit;
  logic [PW-1:0] jmp_slot;
  logic [1:0] ctr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= CLEAR;
      walk_idx <= '0;
    end else begin
      state <= state_n;
      walk_idx <= walk_n;
    end
  end
  always_comb begin
    state_n = flush ? CLEAR : (clr && walk_idx == IDXW'(ENTRIES - 1)) ? RUN : state;
    walk_n = flush ? '0 : clr ? walk_idx + 1'b1 : walk_idx;
  end
  // Readies and the drain all fall silent in a flush cycle
  always_comb begin
    clr = (state == CLEAR);
    br_ready = !clr && !flush && (count < CW'(QDEPTH));
    jmp_ready = !clr && !flush && (({1'b0, count} + (CW+1)'(br_valid)) < (CW+1)'(QDEPTH));
    br_acc = br_valid && br_ready;
    jmp_acc = jmp_valid && jmp_ready;
    deq = !clr && !flush && (count != '0);
    jmp_slot = br_acc ? inc(tail) : tail;
    tail_n = jmp_acc ? inc(jmp_slot) : jmp_slot;
  end
  always_comb begin
    hit = tbl_rvalid && (tbl_rnpc == q_npc[head]);
    ctr = q_kind[head] ? 2'b11 :
          !hit ? {2{q_taken[head]}} :
          q_taken[head] ? ((tbl_rctr == 2'b11) ? 2'b11 : tbl_rctr + 2'd1) :
          ((tbl_rctr == 2'b00) ? 2'b00 : tbl_rctr - 2'd1);
    tbl_ridx = q_npc[head][IDXW+1:2];
    tbl_wen = clr || deq;
    tbl_widx = clr ? walk_idx : tbl_ridx;
    tbl_wvalid = deq;
    tbl_wnpc = deq ? q_npc[head] : '0;
    tbl_wtarget = deq ? q_target[head] : '0;
    tbl_wctr = deq ? ctr : '0;
    busy = clr;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= deq ? inc(head) : head;
      tail <= tail_n;
      count <= count + CW'(br_acc) + CW'(jmp_acc) - CW'(deq);
    end
  end
  always_ff @(posedge CLK) begin
    if (br_acc) begin
      q_kind[tail] <= 1'b0;
      q_taken[tail] <= br_taken;
      q_npc[tail] <= br_npc;
      q_target[tail] <= br_target;
    end
    if (jmp_acc) begin
      q_kind[jmp_slot] <= 1'b1;
      q_taken[jmp_slot] <= 1'b1;
      q_npc[jmp_slot] <= jmp_npc;
      q_target[jmp_slot] <= jmp_target;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed bench for btb_update_ctrl with a behavioural 4-entry BTB table
module tb_btb_update_ctrl;
  localparam int ENTRIES = 4;
  localparam int IDXW = 2;
  logic CLK = 0, nRST = 0, flush = 0;
  logic br_valid = 0, br_taken = 0, jmp_valid = 0;
  logic [31:0] br_npc = 0, br_target = 0, jmp_npc = 0, jmp_target = 0;
  logic br_ready, jmp_ready, tbl_rvalid, tbl_wen, tbl_wvalid, busy;
  logic [IDXW-1:0] tbl_ridx, tbl_widx;
  logic [31:0] tbl_rnpc, tbl_wnpc, tbl_wtarget;
  logic [1:0] tbl_rctr, tbl_wctr;
  logic m_valid [ENTRIES];
  logic [31:0] m_npc [ENTRIES];
  logic [1:0] m_ctr [ENTRIES];
  int checks = 0, passed = 0;

  btb_update_ctrl #(.ENTRIES(ENTRIES), .QDEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .br_valid(br_valid), .br_npc(br_npc), .br_target(br_target), .br_taken(br_taken), .br_ready(br_ready),
    .jmp_valid(jmp_valid), .jmp_npc(jmp_npc), .jmp_target(jmp_target), .jmp_ready(jmp_ready),
    .tbl_ridx(tbl_ridx), .tbl_rvalid(tbl_rvalid), .tbl_rnpc(tbl_rnpc), .tbl_rctr(tbl_rctr),
    .tbl_wen(tbl_wen), .tbl_widx(tbl_widx), .tbl_wvalid(tbl_wvalid), .tbl_wnpc(tbl_wnpc),
    .tbl_wtarget(tbl_wtarget), .tbl_wctr(tbl_wctr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial for (int i = 0; i < ENTRIES; i++) begin
    m_valid[i] = 0;
    m_npc[i] = 0;
    m_ctr[i] = 0;
  end
  assign tbl_rvalid = m_valid[tbl_ridx];
  assign tbl_rnpc = m_npc[tbl_ridx];
  assign tbl_rctr = m_ctr[tbl_ridx];
  always @(posedge CLK) if (tbl_wen) begin
    m_valid[tbl_widx] <= tbl_wvalid;
    m_npc[tbl_widx] <= tbl_wnpc;
    m_ctr[tbl_widx] <= tbl_wctr;
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_br(input logic v, input logic [31:0] n, input logic [31:0] t, input logic tk);
    br_valid = v; br_npc = n; br_target = t; br_taken = tk;
  endtask

  task automatic set_jmp(input logic v, input logic [31:0] n, input logic [31:0] t);
    jmp_valid = v; jmp_npc = n; jmp_target = t;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else passed++;
    checks++; if (tbl_wen !== 1'b1) $display("FAIL rst_wen: got %b want 1", tbl_wen); else passed++;
    checks++; if (tbl_widx !== 2'd0) $display("FAIL rst_widx: got %0d want 0", tbl_widx); else passed++;
    checks++; if (tbl_wvalid !== 1'b0) $display("FAIL rst_wvalid: got %b want 0", tbl_wvalid); else passed++;
    checks++; if ({br_ready, jmp_ready} !== 2'b00) $display("FAIL rst_ready: got %b want 00", {br_ready, jmp_ready}); else passed++;
    @(posedge CLK);
    #1 nRST = 1;
    #1;
    for (int i = 0; i < ENTRIES; i++) begin
      checks++; if ({busy, tbl_wen, tbl_wvalid, tbl_widx} !== {3'b110, IDXW'(i)})
        $display("FAIL walk_%0d: got busy/wen/wvalid/widx %b%b%b/%0d want 110/%0d", i, busy, tbl_wen, tbl_wvalid, tbl_widx, i); else passed++;
      step();
    end
    checks++; if ({busy, br_ready, tbl_wen} !== 3'b010) $display("FAIL walk_done: got busy/br_ready/wen %b want 010", {busy, br_ready, tbl_wen}); else passed++;
  endtask

  task automatic test_cold_branch;
    set_br(1, 32'h104, 32'h200, 1);
    #1;
    checks++; if (br_ready !== 1'b1) $display("FAIL cold_ready: got %b want 1", br_ready); else passed++;
    step();
    set_br(0, 0, 0, 0);
    checks++; if ({tbl_wen, tbl_wvalid, tbl_widx, tbl_wctr} !== 6'b11_01_11)
      $display("FAIL cold_write: got wen/wvalid/widx/wctr %b want 110111", {tbl_wen, tbl_wvalid, tbl_widx, tbl_wctr}); else passed++;
    checks++; if (tbl_wnpc !== 32'h104) $display("FAIL cold_npc: got %h want 00000104", tbl_wnpc); else passed++;
    checks++; if (tbl_wtarget !== 32'h200) $display("FAIL cold_target: got %h want 00000200", tbl_wtarget); else passed++;
    step();
    checks++; if (tbl_wen !== 1'b0) $display("FAIL cold_idle: got wen %b want 0", tbl_wen); else passed++;
  endtask

  task automatic test_counter;
    logic [1:0] exp [5] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 5; i++) begin
      set_br(1, 32'h104, 32'h200, i == 4);
      step();
      checks++; if ({tbl_wen, tbl_wctr} !== {1'b1, exp[i]})
        $display("FAIL ctr_seq_%0d: got wen/ctr %b/%b want 1/%b", i, tbl_wen, tbl_wctr, exp[i]); else passed++;
    end
    set_br(0, 0, 0, 0);
    step();
    checks++; if (tbl_wen !== 1'b0) $display("FAIL ctr_idle: got wen %b want 0", tbl_wen); else passed++;
  endtask

  task automatic test_alias;
    logic [31:0] npc [3] = '{32'h114, 32'h104, 32'h104};
    logic tk [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] exp [3] = '{2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 3; i++) begin
      set_br(1, npc[i], 32'h240, tk[i]);
      step();
      checks++; if ({tbl_widx, tbl_wctr, tbl_wnpc} !== {2'd1, exp[i], npc[i]})
        $display("FAIL alias_%0d: got widx/ctr/npc %0d/%b/%h want 1/%b/%h", i, tbl_widx, tbl_wctr, tbl_wnpc, exp[i], npc[i]); else passed++;
    end
    set_br(0, 0, 0, 0);
    step();
  endtask

  task automatic test_dual;
    set_br(1, 32'h108, 32'h300, 1);
    set_jmp(1, 32'h10C, 32'h400);
    step();
    set_br(1, 32'h110, 32'h500, 0);
    set_jmp(1, 32'h118, 32'h600);
    checks++; if (tbl_wnpc !== 32'h108) $display("FAIL dual_a_br: got npc %h want 00000108", tbl_wnpc); else passed++;
    step();
    set_br(1, 32'h1F0, 32'h0, 1);
    set_jmp(1, 32'h1F4, 32'h0);
    #1;
    checks++; if ({br_ready, jmp_ready} !== 2'b10) $display("FAIL dual_full_ready: got %b want 10", {br_ready, jmp_ready}); else passed++;
    checks++; if ({tbl_wnpc, tbl_wctr} !== {32'h10C, 2'b11}) $display("FAIL dual_a_jmp: got npc/ctr %h/%b want 0000010c/11", tbl_wnpc, tbl_wctr); else passed++;
    br_valid = 0;
    #1;
    checks++; if (jmp_ready !== 1'b1) $display("FAIL dual_jmp_alone: got %b want 1", jmp_ready); else passed++;
    jmp_valid = 0;
    step();
    checks++; if ({tbl_wnpc, tbl_wctr} !== {32'h110, 2'b00}) $display("FAIL dual_b_br: got npc/ctr %h/%b want 00000110/00", tbl_wnpc, tbl_wctr); else passed++;
    set_br(1, 32'h120, 32'h700, 1);
    set_jmp(1, 32'h12C, 32'h800);
    #1;
    checks++; if ({br_ready, jmp_ready} !== 2'b11) $display("FAIL dual_both_ready: got %b want 11", {br_ready, jmp_ready}); else passed++;
    step();
    set_br(0, 0, 0, 0);
    set_jmp(0, 0, 0);
    checks++; if ({tbl_wnpc, tbl_wctr} !== {32'h118, 2'b11}) $display("FAIL dual_b_jmp: got npc/ctr %h/%b want 00000118/11", tbl_wnpc, tbl_wctr); else passed++;
    step();
    checks++; if ({tbl_widx, tbl_wnpc, tbl_wctr} !== {2'd0, 32'h120, 2'b11}) $display("FAIL dual_d_br: got idx/npc/ctr %0d/%h/%b want 0/00000120/11", tbl_widx, tbl_wnpc, tbl_wctr); else passed++;
    step();
    checks++; if ({tbl_widx, tbl_wnpc, tbl_wtarget} !== {2'd3, 32'h12C, 32'h800}) $display("FAIL dual_d_jmp: got idx/npc/tgt %0d/%h/%h want 3/0000012c/00000800", tbl_widx, tbl_wnpc, tbl_wtarget); else passed++;
    step();
    checks++; if (tbl_wen !== 1'b0) $display("FAIL dual_idle: got wen %b want 0", tbl_wen); else passed++;
  endtask

  task automatic test_flush_mid_queue;
    set_br(1, 32'h100, 32'h10, 1);
    set_jmp(1, 32'h104, 32'h20);
    step();
    set_br(1, 32'h108, 32'h30, 1);
    set_jmp(1, 32'h10C, 32'h40);
    step();
    flush = 1;
    #1;
    checks++; if ({br_ready, jmp_ready, tbl_wen} !== 3'b000) $display("FAIL flush_cycle: got br_ready/jmp_ready/wen %b want 000", {br_ready, jmp_ready, tbl_wen}); else passed++;
    step();
    flush = 0;
    set_br(0, 0, 0, 0);
    set_jmp(0, 0, 0);
    for (int i = 0; i < ENTRIES; i++) begin
      checks++; if ({busy, tbl_wen, tbl_wvalid, tbl_widx} !== {3'b110, IDXW'(i)})
        $display("FAIL flush_walk_%0d: got busy/wen/wvalid/widx %b%b%b/%0d want 110/%0d", i, busy, tbl_wen, tbl_wvalid, tbl_widx, i); else passed++;
      step();
    end
    checks++; if ({busy, br_ready, tbl_wen} !== 3'b010) $display("FAIL flush_empty: got busy/br_ready/wen %b want 010", {busy, br_ready, tbl_wen}); else passed++;
  endtask

  task automatic test_back_pressure;
    flush = 1;
    step();
    flush = 0;
    set_br(1, 32'h104, 32'h900, 1);
    set_jmp(1, 32'h108, 32'hA00);
    #1;
    checks++; if ({br_ready, jmp_ready} !== 2'b00) $display("FAIL bp_clear_ready: got %b want 00", {br_ready, jmp_ready}); else passed++;
    step();
    step();
    flush = 1;
    #1;
    checks++; if ({tbl_wen, tbl_widx} !== 3'b1_10) $display("FAIL bp_before_restart: got wen/widx %b want 110", {tbl_wen, tbl_widx}); else passed++;
    step();
    flush = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      checks++; if ({br_ready, jmp_ready, busy, tbl_widx} !== {3'b001, IDXW'(i)})
        $display("FAIL bp_walk_%0d: got ready/busy/widx %b%b%b/%0d want 001/%0d", i, br_ready, jmp_ready, busy, tbl_widx, i); else passed++;
      step();
    end
    checks++; if ({busy, br_ready, jmp_ready} !== 3'b011) $display("FAIL bp_run_ready: got busy/br/jmp %b want 011", {busy, br_ready, jmp_ready}); else passed++;
    step();
    set_br(0, 0, 0, 0);
    set_jmp(0, 0, 0);
    checks++; if ({tbl_widx, tbl_wnpc, tbl_wctr} !== {2'd1, 32'h104, 2'b11}) $display("FAIL bp_first: got idx/npc/ctr %0d/%h/%b want 1/00000104/11", tbl_widx, tbl_wnpc, tbl_wctr); else passed++;
    step();
    checks++; if ({tbl_widx, tbl_wnpc, tbl_wtarget} !== {2'd2, 32'h108, 32'hA00}) $display("FAIL bp_second: got idx/npc/tgt %0d/%h/%h want 2/00000108/00000a00", tbl_widx, tbl_wnpc, tbl_wtarget); else passed++;
    step();
    checks++; if (tbl_wen !== 1'b0) $display("FAIL bp_idle: got wen %b want 0", tbl_wen); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_counter();
    test_alias();
    test_dual();
    test_flush_mid_queue();
    test_back_pressure();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end
endmodule
